// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_pkg
// Brief   : Shared encodings for the unified memory-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_I_ACC = 2'd1;
  localparam logic [1:0] S_D_ACC = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module  : starve_counter
// Brief   : Saturating count of D grants made while a fetch waits.
// Revision: 1.0 - initial release
// ============================================================================
module starve_counter
  import mem_bus_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clear,
  output logic o_limit
);

  localparam logic [CNT_W-1:0] c_limit = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_limit = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one memory port between fetch and data sides; D wins by
//           default, a starvation bound eventually forces a fetch grant.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ready_n,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready_n,
  output logic              d_busy,
  output logic              m_req,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [1:0]        m_size,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready_n
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              w_done;
  logic              w_decide;
  logic              w_limit;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              r_m_req;
  logic              r_m_write;
  logic [ADDR_W-1:0] r_m_addr;
  logic [1:0]        r_m_size;
  logic [DATA_W-1:0] r_m_wdata;

  // Arbitration happens in IDLE and on every completion cycle, so grants chain with no bubble.
  assign w_done    = (r_state != S_IDLE) && !m_ready_n;
  assign w_decide  = (r_state == S_IDLE) || w_done;
  assign w_grant_d = w_decide && d_req && (!i_req || !w_limit);
  assign w_grant_i = w_decide && i_req && !w_grant_d;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_grant_d && i_req),
    .i_clear (w_grant_i || !i_req),
    .o_limit (w_limit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_grant_d) begin
      w_state_next = S_D_ACC;
    end else if (w_grant_i) begin
      w_state_next = S_I_ACC;
    end else if (w_decide) begin
      w_state_next = S_IDLE;
    end
  end

  // The memory side sees only these latched copies, never the live requester inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_req   <= 1'b0;
      r_m_write <= 1'b0;
      r_m_addr  <= '0;
      r_m_size  <= '0;
      r_m_wdata <= '0;
    end else if (w_grant_d) begin
      r_m_req   <= 1'b1;
      r_m_write <= d_write;
      r_m_addr  <= d_addr;
      r_m_size  <= d_size;
      r_m_wdata <= d_wdata;
    end else if (w_grant_i) begin
      r_m_req   <= 1'b1;
      r_m_write <= 1'b0;
      r_m_addr  <= i_addr;
      r_m_size  <= SZ_WORD;
      r_m_wdata <= '0;
    end else if (w_done) begin
      r_m_req   <= 1'b0;
    end
  end

  assign m_req   = r_m_req;
  assign m_write = r_m_write;
  assign m_addr  = r_m_addr;
  assign m_size  = r_m_size;
  assign m_wdata = r_m_wdata;

  always_comb begin
    i_ready_n = 1'b1;
    d_ready_n = 1'b1;
    i_data    = '0;
    d_rdata   = '0;
    if (w_done && (r_state == S_I_ACC)) begin
      i_ready_n = 1'b0;
      i_data    = m_rdata;
    end
    if (w_done && (r_state == S_D_ACC)) begin
      d_ready_n = 1'b0;
      d_rdata   = m_rdata;
    end
    // Gated by reset so a held d_req cannot report busy while the port is being reset.
    d_busy = rst && ((d_req && (r_state != S_D_ACC)) ||
                     ((r_state == S_D_ACC) && m_ready_n));
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Scoreboard bench for the fetch/data memory-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_ready_n;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready_n;
  logic        d_busy;
  logic        m_req;
  logic        m_write;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready_n;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_LIMIT (4),
    .ADDR_W       (32),
    .DATA_W       (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_ready_n (i_ready_n),
    .d_req     (d_req),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_size    (d_size),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready_n (d_ready_n),
    .d_busy    (d_busy),
    .m_req     (m_req),
    .m_write   (m_write),
    .m_addr    (m_addr),
    .m_size    (m_size),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready_n (m_ready_n)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_i_str  = 0;
  int   n_d_str  = 0;
  int   mem_wait = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0010_0093;
      32'h0000_3000: return 32'h1234_5678;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic wait_strobe(input bit want_d, input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (((want_d ? d_ready_n : i_ready_n) == 1'b1) && (cyc < 50));
    check({name, "_strobe"}, {31'b0, (want_d ? d_ready_n : i_ready_n)}, 32'd0);
  endtask

  // Memory responder: answers after mem_wait wait-state cycles of m_req.
  initial begin
    int wcnt;
    wcnt      = 0;
    m_ready_n = 1'b1;
    m_rdata   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!m_ready_n) wcnt = 0;
      if (m_req && rst) begin
        if (wcnt == mem_wait) begin
          m_ready_n = 1'b0;
          m_rdata   = mem_model(m_addr);
        end else begin
          m_ready_n = 1'b1;
          m_rdata   = 32'hBAD0_BAD0;
          wcnt++;
        end
      end else begin
        m_ready_n = 1'b1;
        m_rdata   = 32'hBAD0_BAD0;
        wcnt      = 0;
      end
    end
  end

  // Scoreboard monitor: every response strobe pops one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!i_ready_n || !d_ready_n) begin
        if (!i_ready_n) n_i_str++;
        if (!d_ready_n) n_d_str++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_strobe: got i_ready_n=%b d_ready_n=%b, expected no strobe",
                   i_ready_n, d_ready_n);
        end else begin
          e = exp_q.pop_front();
          check("strobe_side", {30'b0, d_ready_n, i_ready_n}, e.is_d ? 32'd1 : 32'd2);
          check("resp_data", e.is_d ? d_rdata : i_data, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int d0;
    int i0;
    int stable;
    int early;

    rst = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b1; d_write = 1'b0; d_addr = '0; d_size = SZ_BYTE; d_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_m_req",     {31'b0, m_req},     32'd0);
    check("rst_m_write",   {31'b0, m_write},   32'd0);
    check("rst_m_addr",    m_addr,             32'd0);
    check("rst_m_size",    {30'b0, m_size},    32'd0);
    check("rst_m_wdata",   m_wdata,            32'd0);
    check("rst_i_ready_n", {31'b0, i_ready_n}, 32'd1);
    check("rst_d_ready_n", {31'b0, d_ready_n}, 32'd1);
    check("rst_d_busy",    {31'b0, d_busy},    32'd0);
    check("rst_i_data",    i_data,             32'd0);
    check("rst_d_rdata",   d_rdata,            32'd0);
    d_req = 1'b0;
    rst   = 1'b1;
    @(negedge clk);

    // Lone fetch, memory answers in the first m_req cycle.
    mem_wait = 0;
    exp_q.push_back('{1'b0, 32'h0010_0093});
    i_req = 1'b1; i_addr = 32'h0000_0100;
    @(negedge clk);
    check("fetch_m_req",   {31'b0, m_req},     32'd1);
    check("fetch_m_addr",  m_addr,             32'h100);
    check("fetch_m_size",  {30'b0, m_size},    32'd2);
    check("fetch_m_write", {31'b0, m_write},   32'd0);
    check("fetch_latency", {31'b0, i_ready_n}, 32'd0);
    check("fetch_d_busy",  {31'b0, d_busy},    32'd0);
    i_req = 1'b0;
    @(negedge clk);
    check("fetch_end_m_req",     {31'b0, m_req},     32'd0);
    check("fetch_end_i_ready_n", {31'b0, i_ready_n}, 32'd1);
    check("fetch_end_d_busy",    {31'b0, d_busy},    32'd0);

    // Starvation bound: four D accesses, then the fetch.
    d0 = n_d_str; i0 = n_i_str;
    repeat (4) exp_q.push_back('{1'b1, mem_model(32'h4000)});
    exp_q.push_back('{1'b0, mem_model(32'h200)});
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h4000; d_size = SZ_WORD;
    i_req = 1'b1; i_addr = 32'h200;
    wait_strobe(1'b0, "starve_fetch", cyc);
    #1;
    i_req = 1'b0; d_req = 1'b0;
    check("starve_d_count", n_d_str - d0, 32'd4);
    check("starve_i_count", n_i_str - i0, 32'd1);
    check("starve_cycles",  cyc,          32'd5);
    @(negedge clk);
    check("starve_end_m_req", {31'b0, m_req}, 32'd0);

    // Store precedence and back-to-back fetch; D first also shows the counter cleared.
    mem_wait = 1;
    exp_q.push_back('{1'b1, mem_model(32'h2000)});
    exp_q.push_back('{1'b0, mem_model(32'h104)});
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h2000; d_size = SZ_BYTE; d_wdata = 32'hAB;
    i_req = 1'b1; i_addr = 32'h104;
    @(negedge clk);
    check("store_m_req",   {31'b0, m_req},   32'd1);
    check("store_m_write", {31'b0, m_write}, 32'd1);
    check("store_m_addr",  m_addr,           32'h2000);
    check("store_m_size",  {30'b0, m_size},  32'd0);
    check("store_m_wdata", m_wdata,          32'hAB);
    check("store_d_busy",  {31'b0, d_busy},  32'd1);
    @(negedge clk);
    check("store_strobe",       {31'b0, d_ready_n}, 32'd0);
    check("store_done_d_busy",  {31'b0, d_busy},    32'd0);
    d_req = 1'b0; d_write = 1'b0;
    @(negedge clk);
    check("b2b_m_req",   {31'b0, m_req},   32'd1);
    check("b2b_m_addr",  m_addr,           32'h104);
    check("b2b_m_size",  {30'b0, m_size},  32'd2);
    check("b2b_m_write", {31'b0, m_write}, 32'd0);
    wait_strobe(1'b0, "b2b_fetch", cyc);
    check("b2b_fetch_cycles", cyc, 32'd1);
    i_req = 1'b0;
    @(negedge clk);
    check("b2b_end_m_req", {31'b0, m_req}, 32'd0);

    // Wait states on a load; requester address changes mid-access.
    mem_wait = 7;
    exp_q.push_back('{1'b1, 32'h1234_5678});
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h3000; d_size = SZ_WORD;
    stable = 0; early = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) d_addr = 32'h9999_0000;
      if (m_req && (m_addr == 32'h3000)) stable++;
      if ((k < 7) && !d_ready_n) early++;
    end
    check("wait_stable",   stable,             32'd8);
    check("wait_no_early", early,              32'd0);
    check("wait_strobe",   {31'b0, d_ready_n}, 32'd0);
    check("wait_rdata",    d_rdata,            32'h1234_5678);
    d_req = 1'b0;
    @(negedge clk);

    // Fetch request dropped after its grant; pending D follows.
    mem_wait = 2;
    d0 = n_d_str; i0 = n_i_str;
    exp_q.push_back('{1'b0, mem_model(32'h180)});
    exp_q.push_back('{1'b1, mem_model(32'h5000)});
    i_req = 1'b1; i_addr = 32'h180;
    @(negedge clk);
    check("drop_m_addr", m_addr, 32'h180);
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b1; d_addr = 32'h5000; d_write = 1'b0; d_size = SZ_WORD;
    @(negedge clk);
    check("drop_d_busy",    {31'b0, d_busy}, 32'd1);
    check("drop_addr_held", m_addr,          32'h180);
    wait_strobe(1'b0, "drop_fetch", cyc);
    wait_strobe(1'b1, "drop_load", cyc);
    #1;
    d_req = 1'b0;
    check("drop_i_count", n_i_str - i0, 32'd1);
    check("drop_d_count", n_d_str - d0, 32'd1);
    @(negedge clk);

    // Reset asserted mid-way through a D access.
    mem_wait = 10;
    d0 = n_d_str;
    d_req = 1'b1; d_addr = 32'h6000; d_write = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_in_flight", {31'b0, m_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_m_req",     {31'b0, m_req},     32'd0);
    check("rstmid_d_busy",    {31'b0, d_busy},    32'd0);
    check("rstmid_d_ready_n", {31'b0, d_ready_n}, 32'd1);
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rstmid_idle_m_req",  {31'b0, m_req},  32'd0);
    check("rstmid_idle_d_busy", {31'b0, d_busy}, 32'd0);
    check("rstmid_no_strobe",   n_d_str - d0,    32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
